// File: rtl/line_mem_responder.sv
// Cache-line SRAM responder: accepts a line read/write, waits LAT cycles, then issues four word beats.
// mem_ready pulses at cycle LAT+5 (write) or LAT+6 (read); new requests are ignored until back in IDLE.
module line_mem_responder #(
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         sram_cs,
  output logic         sram_we,
  output logic [29:0]  sram_addr,
  output logic [31:0]  sram_wdata,
  input  logic [31:0]  sram_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_BEAT    = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [3:0] WAIT_INIT  = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
  localparam logic [2:0] AFTER_ACPT = (LAT > 0) ? S_WAIT : S_BEAT;

  logic [2:0]   state;
  logic [3:0]   wait_cnt;
  logic [1:0]   beat;
  logic         op_wr;
  logic [27:0]  addr_q;
  logic [127:0] line_q;
  logic         cap_vld;
  logic [1:0]   cap_idx;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      beat      <= 2'd0;
      op_wr     <= 1'b0;
      addr_q    <= 28'd0;
      line_q    <= 128'd0;
      cap_vld   <= 1'b0;
      cap_idx   <= 2'd0;
      mem_rdata <= 128'd0;
    end else begin
      // SRAM read data lags its strobe by one cycle, so capture is tracked one beat behind
      cap_vld <= (state == S_BEAT) && !op_wr;
      cap_idx <= beat;
      for (int w = 0; w < 4; w++) begin
        if (cap_vld && cap_idx == 2'(w)) mem_rdata[32*w +: 32] <= sram_rdata;
      end

      case (state)
        S_IDLE: begin
          if (mem_write || mem_read) begin
            op_wr    <= mem_write;
            addr_q   <= mem_addr;
            line_q   <= mem_wdata;
            beat     <= 2'd0;
            wait_cnt <= WAIT_INIT;
            state    <= AFTER_ACPT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_BEAT;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_BEAT: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= op_wr ? S_DONE : S_COLLECT;
        end
        S_COLLECT: state <= S_DONE;
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign mem_ready = (state == S_DONE);
  assign sram_cs   = (state == S_BEAT);
  assign sram_we   = (state == S_BEAT) && op_wr;
  assign sram_addr = {addr_q, beat};

  always_comb begin
    sram_wdata = line_q[31:0];
    case (beat)
      2'd1:    sram_wdata = line_q[63:32];
      2'd2:    sram_wdata = line_q[95:64];
      2'd3:    sram_wdata = line_q[127:96];
      default: sram_wdata = line_q[31:0];
    endcase
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: LAT=2 and LAT=0 instances, shared SRAM model, transaction-level reference model.
`timescale 1ns/1ps
module tb_line_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         proc_reset;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         rd [2];
  logic         wr [2];
  logic [127:0] rdata [2];
  logic         ready [2];
  logic         cs [2];
  logic         we [2];
  logic [29:0]  saddr [2];
  logic [31:0]  swdata [2];
  logic [31:0]  sram_rdata;

  int total = 0;
  int bad = 0;

  line_mem_responder #(.LAT(2)) u_dut (
    .clk(clk), .proc_reset(proc_reset), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata[0]), .mem_ready(ready[0]),
    .sram_cs(cs[0]), .sram_we(we[0]), .sram_addr(saddr[0]), .sram_wdata(swdata[0]),
    .sram_rdata(sram_rdata)
  );

  line_mem_responder #(.LAT(0)) u_dut0 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata[1]), .mem_ready(ready[1]),
    .sram_cs(cs[1]), .sram_we(we[1]), .sram_addr(saddr[1]), .sram_wdata(swdata[1]),
    .sram_rdata(sram_rdata)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word-addressed SRAM shared by both instances (they are never active together)
  logic [31:0] sram [logic [29:0]];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs[i] === 1'b1) begin
        if (we[i]) sram[saddr[i]] = swdata[i];
        else       sram_rdata <= sram.exists(saddr[i]) ? sram[saddr[i]] : 32'h0;
      end
    end
  end

  // Reference model: per transaction, cycle index since acceptance decides every output
  logic [31:0]  ref_mem [logic [29:0]];
  int           lat [2] = '{2, 0};
  bit           m_ok [2];
  bit           m_busy [2];
  bit           m_op [2];
  int           m_cyc [2];
  logic [27:0]  m_addr [2];
  logic [127:0] m_line [2];
  logic [127:0] m_rline [2];

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_busy[i] && m_op[i] && m_cyc[i] >= lat[i] + 1 && m_cyc[i] <= lat[i] + 4)
        ref_mem[{m_addr[i], 2'(m_cyc[i] - lat[i] - 1)}] = m_line[i][32*(m_cyc[i] - lat[i] - 1) +: 32];
      if (proc_reset) begin
        m_ok[i] = 1'b1;
        m_busy[i] = 1'b0;
        m_rline[i] = '0;
      end else if (m_ok[i]) begin
        if (m_busy[i]) begin
          if (m_cyc[i] == (m_op[i] ? lat[i] + 5 : lat[i] + 6)) m_busy[i] = 1'b0;
          else begin
            m_cyc[i]++;
            if (!m_op[i] && m_cyc[i] == lat[i] + 6)
              m_rline[i] = {ref_rd({m_addr[i], 2'd3}), ref_rd({m_addr[i], 2'd2}),
                            ref_rd({m_addr[i], 2'd1}), ref_rd({m_addr[i], 2'd0})};
          end
        end else if (wr[i] || rd[i]) begin
          m_busy[i] = 1'b1;
          m_cyc[i]  = 1;
          m_op[i]   = wr[i];
          m_addr[i] = mem_addr;
          m_line[i] = mem_wdata;
        end
      end
    end
  end

  bit e_cs, e_rdy;
  int e_k;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_ok[i]) begin
        e_cs  = m_busy[i] && m_cyc[i] >= lat[i] + 1 && m_cyc[i] <= lat[i] + 4;
        e_k   = m_cyc[i] - lat[i] - 1;
        e_rdy = m_busy[i] && m_cyc[i] == (m_op[i] ? lat[i] + 5 : lat[i] + 6);
        check($sformatf("m%0d_cs", i), cs[i], e_cs);
        check($sformatf("m%0d_we", i), we[i], e_cs && m_op[i]);
        check($sformatf("m%0d_ready", i), ready[i], e_rdy);
        if (e_cs) check($sformatf("m%0d_addr", i), saddr[i], {m_addr[i], 2'(e_k)});
        if (e_cs && m_op[i]) check($sformatf("m%0d_wdata", i), swdata[i], m_line[i][32*e_k +: 32]);
        if (!(m_busy[i] && !m_op[i]) || e_rdy) check($sformatf("m%0d_rdata", i), rdata[i], m_rline[i]);
      end
    end
  end

  // Called in cycle 0 (request already driven); returns in the IDLE cycle after DONE with requests dropped
  task automatic watch(input int i, input int first, input int rdy, input logic [29:0] base,
                       input bit exp_we, input logic [127:0] line, input bit drop, input string tag);
    for (int n = 0; n <= rdy; n++) begin
      @(negedge clk);
      if (n >= first && n < first + 4) begin
        check({tag, "_cs"}, cs[i], 1'b1);
        check({tag, "_we"}, we[i], exp_we);
        check({tag, "_addr"}, saddr[i], base + 30'(n - first));
        if (exp_we) check({tag, "_wdata"}, swdata[i], line[32*(n - first) +: 32]);
      end else begin
        check({tag, "_cs_off"}, cs[i], 1'b0);
      end
      check({tag, "_ready"}, ready[i], n == rdy);
      @(posedge clk); #1;
      if (drop && n == 0) begin rd[i] = 1'b0; wr[i] = 1'b0; end
    end
    rd[i] = 1'b0;
    wr[i] = 1'b0;
  endtask

  localparam logic [127:0] L5  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L9  = 128'h99999999_88888888_77777777_66666666;
  localparam logic [127:0] L3A = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] L3B = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [127:0] L3X = 128'hA3A3A3A3_A2A2A2A2_B1B1B1B1_B0B0B0B0;
  localparam logic [127:0] LD  = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;

  task automatic rand_inputs();
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'($urandom);
      wr[i] = 1'($urandom);
    end
    mem_addr  = 28'($urandom);
    mem_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    proc_reset = 1'b1;
    rand_inputs();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      rand_inputs();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("rst_ready", ready[i], 1'b0);
        check("rst_cs", cs[i], 1'b0);
        check("rst_we", we[i], 1'b0);
        check("rst_addr", saddr[i], 30'h0);
        check("rst_wdata", swdata[i], 32'h0);
        check("rst_rdata", rdata[i], 128'h0);
      end
    end

    // Request presented on the very first cycle with reset low
    @(posedge clk); #1;
    proc_reset = 1'b0;
    rd = '{1'b0, 1'b0};
    wr = '{1'b1, 1'b0};
    mem_addr = 28'h0000005; mem_wdata = L5;
    watch(0, 3, 7, 30'h14, 1'b1, L5, 1'b0, "wr5");

    rd[0] = 1'b1; mem_addr = 28'h0000005; mem_wdata = '0;
    watch(0, 3, 8, 30'h14, 1'b0, '0, 1'b0, "rd5");
    check("rd5_line", rdata[0], L5);

    wr[0] = 1'b1; mem_addr = 28'h0000009; mem_wdata = L9;
    watch(0, 3, 7, 30'h24, 1'b1, L9, 1'b0, "wr9");
    check("wr9_rdata_held", rdata[0], L5);
    rd[0] = 1'b1; mem_addr = 28'h0000005;
    watch(0, 3, 8, 30'h14, 1'b0, '0, 1'b0, "rd5_nogap");
    check("rd5_nogap_line", rdata[0], L5);

    wr[0] = 1'b1; mem_addr = 28'h0000003; mem_wdata = L3A;
    watch(0, 3, 7, 30'h0C, 1'b1, L3A, 1'b0, "wr3a");
    // Aborted write: reset lands on the edge that would start beat 2
    wr[0] = 1'b1; mem_addr = 28'h0000003; mem_wdata = L3B;
    repeat (4) begin @(posedge clk); #1; end
    proc_reset = 1'b1; wr[0] = 1'b0;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("abort_cs", cs[0], 1'b0);
      check("abort_ready", ready[0], 1'b0);
      @(posedge clk); #1;
    end
    check("abort_sram_c", sram[30'h0C], 32'hB0B0B0B0);
    check("abort_sram_d", sram[30'h0D], 32'hB1B1B1B1);
    check("abort_sram_e", sram[30'h0E], 32'hA2A2A2A2);
    check("abort_sram_f", sram[30'h0F], 32'hA3A3A3A3);
    rd[0] = 1'b1; mem_addr = 28'h0000003;
    watch(0, 3, 8, 30'h0C, 1'b0, '0, 1'b0, "rd3");
    check("rd3_line", rdata[0], L3X);

    // Request dropped right after acceptance still completes
    rd[0] = 1'b1; mem_addr = 28'h0000009;
    watch(0, 3, 8, 30'h24, 1'b0, '0, 1'b1, "rd9_drop");
    check("rd9_line", rdata[0], L9);

    // LAT=0 instance: both requests high means a write
    rd[1] = 1'b1; wr[1] = 1'b1; mem_addr = 28'h0000010; mem_wdata = LD;
    watch(1, 1, 5, 30'h40, 1'b1, LD, 1'b0, "l0_both");
    rd[1] = 1'b1; mem_addr = 28'h0000010; mem_wdata = '0;
    watch(1, 1, 6, 30'h40, 1'b0, '0, 1'b0, "l0_rd");
    check("l0_rd_line", rdata[1], LD);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 Parameter LAT, default 2: wait cycles between request acceptance and first SRAM beat; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 proc_reset  input  1  reset; synchronous and active-high.
REQ-004 mem_read  input  1  line read request from cache; held until mem_ready seen.
REQ-005 mem_write  input  1  line write (write-back) request from cache; held until mem_ready seen.
REQ-006 mem_addr  input  28  line address (word address bits [29:2]).
REQ-007 mem_wdata  input  128  write line; word k at bits [32k+31:32k].
REQ-008 mem_rdata  output  128  read line, registered; word k at bits [32k+31:32k].
REQ-009 mem_ready  output  1  one-cycle completion pulse.
REQ-010 sram_cs  output  1  SRAM word access strobe.
REQ-011 sram_we  output  1  SRAM write enable, meaningful only with sram_cs.
REQ-012 sram_addr  output  30  SRAM word address.
REQ-013 sram_wdata  output  32  SRAM write word.
REQ-014 sram_rdata  input  32  SRAM read word, valid the cycle after a read strobe.

Function
REQ-015 States: IDLE, WAIT, BEAT, COLLECT, DONE; all outputs registered or decoded from state only, no input-to-output combinational path.
REQ-016 IDLE: if mem_write or mem_read is high at a clock edge, latch mem_addr, mem_wdata and op (write wins when both high); next state WAIT if LAT>0, else BEAT.
REQ-017 Acceptance cycle = cycle 0; WAIT occupies cycles 1..LAT via down-counter; requests ignored outside IDLE.
REQ-018 BEAT: four consecutive cycles, beat counter k = 0,1,2,3; sram_cs=1, sram_addr={latched addr, k[1:0]}, sram_we=op.
REQ-019 Write beat: sram_wdata = latched word k; after beat 3 go to DONE; mem_ready high in cycle LAT+5.
REQ-020 Read beat: sram_rdata arriving in the cycle after beat k is stored to line-buffer word k; after beat 3 go to COLLECT (captures word 3), then DONE; mem_ready high in cycle LAT+6.
REQ-021 DONE: mem_ready=1 for exactly one cycle, then IDLE; mem_rdata already holds the complete new line during that cycle.
REQ-022 mem_rdata updates only on read transactions and holds its value through writes and idle periods.
REQ-023 A request present in the first IDLE cycle after DONE is accepted immediately (write-back followed by refill has zero idle gap).
REQ-024 Request deasserted mid-transaction (protocol violation): transaction still completes with all four beats and mem_ready pulse.
REQ-025 sram_cs=0, sram_we=0 in IDLE, WAIT, COLLECT, DONE; exactly four SRAM strobes per transaction.

Reset
REQ-026 proc_reset high at a clock edge: state IDLE, counters 0, mem_ready=0, mem_rdata=0, sram_cs=0, sram_we=0, sram_addr=0, sram_wdata=0, latched request cleared.
REQ-027 Reset mid-transaction aborts it: no further SRAM strobes, no mem_ready pulse; beats already written remain in SRAM.
REQ-028 First request after reset release is accepted on the first edge with proc_reset low.

Verification (LAT=2 unless stated)
REQ-029 Reset: hold proc_reset 2 cycles with random inputs -> all outputs 0, no sram_cs.
REQ-030 Write mem_addr=28'h0000005, mem_wdata=128'h44444444_33333333_22222222_11111111 -> sram writes 30'h14..30'h17 with 11111111,22222222,33333333,44444444 in cycles 3..6; mem_ready only in cycle 7.
REQ-031 Read of same line after REQ-030 -> sram reads 30'h14..30'h17 in cycles 3..6; mem_ready only in cycle 8 with mem_rdata equal to written line.
REQ-032 Write line 28'h0000009 then read line 28'h0000005 issued the cycle after mem_ready -> read accepted with no gap; mem_rdata returns REQ-030 data; mem_rdata unchanged during the write.
REQ-033 Reset asserted during beat k=2 of a write to 28'h0000003 -> only 30'hC, 30'hD written, no mem_ready; next read of that line returns new words 0,1 and old words 2,3.
REQ-034 mem_read and mem_write both high, then LAT=0 build -> write performed; mem_ready in cycle 5 (write) and cycle 6 (read).
